dmem_arbiter: RTL and testbench

//  Two-requester arbiter and sequencer in front of the single-port Data_Memory.

---
 rtl/dmem_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port fixed-priority arbiter/sequencer in front of the single-port Data_Memory.
// Port 0 (MEM stage) has priority. An anti-starvation counter forces a port-1 grant after MAX_CONSEC port-0 wins.
// Optional macro DMEM_ALIGN_CHECK_EN: when it is defined, a misaligned access skips the memory cycle and returns an error response.
module dmem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              req1_ready_o,
  output logic              resp0_valid_o,
  output logic [DATA_W-1:0] resp0_rdata_o,
  output logic              resp0_err_o,
  output logic              resp1_valid_o,
  output logic [DATA_W-1:0] resp1_rdata_o,
  output logic              resp1_err_o,
  output logic              mem_MemWrite_o,
  output logic              mem_MemRead_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  input  logic [DATA_W-1:0] mem_read_data_i
);
`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif
  localparam int CW = $clog2(MAX_CONSEC + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            state_q;
  logic [CW-1:0]     consec_q, consec_d;
  logic              write_q, owner_q, mis_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              resp0_q, resp1_q, err_q;
  logic              pick1, grant, sel_write, sel_mis;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  // arbitration: port 1 wins when alone or when port 0 has used up its consecutive budget
  always_comb begin
    pick1     = req1_valid_i && (!req0_valid_i || consec_q == CW'(MAX_CONSEC));
    grant     = reset_n && state_q == IDLE && (req0_valid_i || req1_valid_i);
    sel_write = pick1 ? req1_write_i : req0_write_i;
    sel_addr  = pick1 ? req1_addr_i : req0_addr_i;
    sel_wdata = pick1 ? req1_wdata_i : req0_wdata_i;
    sel_mis   = ALIGN_EN && (sel_addr[2:0] != 3'b000);
    consec_d  = pick1 ? '0 : !req1_valid_i ? '0 :
                consec_q == CW'(MAX_CONSEC) ? consec_q : consec_q + 1'b1;
  end
  assign req0_ready_o     = grant && !pick1;
  assign req1_ready_o     = grant && pick1;
  assign mem_MemWrite_o   = reset_n && state_q == BUSY && write_q && !mis_q;
  assign mem_MemRead_o    = reset_n && state_q == BUSY && !write_q && !mis_q;
  assign mem_addr_o       = addr_q;
  assign mem_write_data_o = wdata_q;
  assign resp0_valid_o    = resp0_q;
  assign resp1_valid_o    = resp1_q;
  assign resp0_rdata_o    = resp0_q ? rdata_q : '0;
  assign resp1_rdata_o    = resp1_q ? rdata_q : '0;
  assign resp0_err_o      = resp0_q && err_q;
  assign resp1_err_o      = resp1_q && err_q;
  // IDLE/BUSY sequencer: latch the winner, run one memory cycle, then pulse the owner's response
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      consec_q <= '0;
      write_q  <= 1'b0;
      owner_q  <= 1'b0;
      mis_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      resp0_q  <= 1'b0;
      resp1_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      resp0_q <= state_q == BUSY && !owner_q;
      resp1_q <= state_q == BUSY && owner_q;
      err_q   <= state_q == BUSY && mis_q;
      rdata_q <= (state_q == BUSY && !write_q && !mis_q) ? mem_read_data_i : '0;
      if (grant) begin
        state_q  <= BUSY;
        consec_q <= consec_d;
        write_q  <= sel_write;
        owner_q  <= pick1;
        mis_q    <= sel_mis;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
      end else if (state_q == BUSY) begin
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, hand-written corner sequences and random traffic against a transaction-level model.
module tb_dmem_arbiter;
  localparam int MAXC = 4;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [63:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic [63:0] resp0_rdata, resp1_rdata;
  logic        mem_MemWrite, mem_MemRead;
  logic [63:0] mem_addr, mem_write_data, mem_read_data;
  logic [63:0] dmem [64] = '{default: 64'h0};
  logic [63:0] refmem [64] = '{default: 64'h0};
  int total = 0, bad = 0;
  int n_r0 = 0, n_r1 = 0, n_mw = 0, n_mr = 0;
  logic [63:0] last_r0 = 0, last_r1 = 0;
  logic last_e0 = 0, last_e1 = 0;
  int gq[$];
  bit m_busy = 0, m_own = 0, m_w = 0, m_mis = 0, m_rv0 = 0, m_rv1 = 0, m_re = 0;
  logic [63:0] m_a = 0, m_d = 0, m_rd = 0;
  int m_cnt = 0;

  typedef struct {int p; bit w; logic [63:0] a; logic [63:0] d; logic [63:0] er;} vec_t;
  vec_t vt[10];
  int exp_g[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_MemWrite) dmem[mem_addr[8:3]] <= mem_write_data;
  assign mem_read_data = dmem[mem_addr[8:3]];

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_CONSEC(MAXC)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid_i(req0_valid), .req0_write_i(req0_write), .req0_addr_i(req0_addr),
    .req0_wdata_i(req0_wdata), .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_write_i(req1_write), .req1_addr_i(req1_addr),
    .req1_wdata_i(req1_wdata), .req1_ready_o(req1_ready),
    .resp0_valid_o(resp0_valid), .resp0_rdata_o(resp0_rdata), .resp0_err_o(resp0_err),
    .resp1_valid_o(resp1_valid), .resp1_rdata_o(resp1_rdata), .resp1_err_o(resp1_err),
    .mem_MemWrite_o(mem_MemWrite), .mem_MemRead_o(mem_MemRead), .mem_addr_o(mem_addr),
    .mem_write_data_o(mem_write_data), .mem_read_data_i(mem_read_data));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // every cycle: compare against the transaction model, then advance the model over the coming edge
  task automatic monitor();
    forever begin
      bit e0, e1;
      @(negedge clk);
      e1 = reset_n && !m_busy && req1_valid && (!req0_valid || m_cnt == MAXC);
      e0 = reset_n && !m_busy && req0_valid && !e1;
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("memwrite", mem_MemWrite, reset_n && m_busy && m_w && !m_mis);
      chk("memread", mem_MemRead, reset_n && m_busy && !m_w && !m_mis);
      if (m_busy && reset_n) begin
        chk("mem_addr", mem_addr, m_a);
        if (m_w) chk("mem_wdata", mem_write_data, m_d);
      end
      chk("resp0_valid", resp0_valid, m_rv0);
      chk("resp1_valid", resp1_valid, m_rv1);
      chk("resp0_rdata", resp0_rdata, m_rv0 ? m_rd : 64'h0);
      chk("resp1_rdata", resp1_rdata, m_rv1 ? m_rd : 64'h0);
      chk("resp0_err", resp0_err, m_rv0 && m_re);
      chk("resp1_err", resp1_err, m_rv1 && m_re);
      if (resp0_valid) begin n_r0++; last_r0 = resp0_rdata; last_e0 = resp0_err; end
      if (resp1_valid) begin n_r1++; last_r1 = resp1_rdata; last_e1 = resp1_err; end
      if (mem_MemWrite) n_mw++;
      if (mem_MemRead) n_mr++;
      if (req0_valid && req0_ready) gq.push_back(0);
      if (req1_valid && req1_ready) gq.push_back(1);
      if (!reset_n) begin
        m_busy = 0; m_rv0 = 0; m_rv1 = 0; m_re = 0; m_rd = 0; m_cnt = 0;
      end else begin
        m_rv0 = m_busy && !m_own;
        m_rv1 = m_busy && m_own;
        m_re  = m_busy && m_mis;
        m_rd  = (m_busy && !m_w && !m_mis) ? refmem[m_a[8:3]] : 64'h0;
        if (m_busy && m_w && !m_mis) refmem[m_a[8:3]] = m_d;
        m_busy = e0 || e1;
        if (m_busy) begin
          m_own = e1;
          m_w   = e1 ? req1_write : req0_write;
          m_a   = e1 ? req1_addr : req0_addr;
          m_d   = e1 ? req1_wdata : req0_wdata;
          m_mis = ALIGN && (m_a[2:0] != 3'b000);
          m_cnt = e1 ? 0 : !req1_valid ? 0 : (m_cnt == MAXC ? MAXC : m_cnt + 1);
        end
      end
    end
  endtask

  task automatic issue(input int p, input bit w, input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    bit rdy = 0;
    if (p == 0) begin req0_write = w; req0_addr = a; req0_wdata = d; req0_valid = 1; end
    else begin req1_write = w; req1_addr = a; req1_wdata = d; req1_valid = 1; end
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = (p == 0) ? req0_ready : req1_ready;
      n++;
    end
    if (!rdy) begin
      total++; bad++;
      $display("FAIL accept_timeout port%0d: got no ready want ready within 200 cycles", p);
    end
    @(posedge clk);
    #1;
    if (p == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    cycles(2);
    reset_n = 1;
  endtask

  task automatic rnd_port(input int p);
    repeat (40) begin
      logic [63:0] a;
      repeat ($urandom_range(0, 3)) cycles(1);
      a = 64'($urandom_range(0, 15)) << 3;
      if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
      issue(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, q;
    vt[0] = '{0, 1, 64'd24,  64'h0000_0000_0000_A5A5, 64'h0};
    vt[1] = '{1, 0, 64'd24,  64'h0,                   64'h0000_0000_0000_A5A5};
    vt[2] = '{1, 1, 64'd32,  64'h0000_0000_DEAD_BEEF, 64'h0};
    vt[3] = '{0, 0, 64'd32,  64'h0,                   64'h0000_0000_DEAD_BEEF};
    vt[4] = '{0, 0, 64'd40,  64'h0,                   64'h0};
    vt[5] = '{1, 1, 64'd24,  64'h0000_0000_0000_1234, 64'h0};
    vt[6] = '{0, 0, 64'd24,  64'h0,                   64'h0000_0000_0000_1234};
    vt[7] = '{1, 0, 64'd504, 64'h0,                   64'h0};
    vt[8] = '{0, 1, 64'd504, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vt[9] = '{1, 0, 64'd504, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF};
    reset_n = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    req0_valid = 1; req0_write = 1; req0_addr = 0; req0_wdata = 64'hC0DE_0000_0000_0001;
    fork monitor(); join_none
    // reset held 2 cycles with a store pending, then the held store goes through
    cycles(2);
    chk("rst_no_memwrite", 64'(n_mw), 64'd0);
    chk("rst_no_resp", 64'(n_r0), 64'd0);
    reset_n = 1;
    issue(0, 1, 0, 64'hC0DE_0000_0000_0001);
    chk("t1_not_yet_committed", dmem[0], 64'h0);
    cycles(1);
    chk("t1_committed", dmem[0], 64'hC0DE_0000_0000_0001);
    cycles(1);
    // store then load on port 0
    p = n_r0;
    issue(0, 1, 0, 64'h1122_3344_5566_7788);
    issue(0, 0, 0, 64'h0);
    cycles(2);
    chk("t2_pulses", 64'(n_r0 - p), 64'd2);
    chk("t2_load_data", last_r0, 64'h1122_3344_5566_7788);
    // single-request vector table
    for (int i = 0; i < 10; i++) begin
      p = n_r0; q = n_r1;
      issue(vt[i].p, vt[i].w, vt[i].a, vt[i].d);
      cycles(2);
      chk($sformatf("vec%0d_rdata", i), vt[i].p ? last_r1 : last_r0, vt[i].er);
      chk($sformatf("vec%0d_err", i), vt[i].p ? last_e1 : last_e0, 64'h0);
      chk($sformatf("vec%0d_own_pulse", i), 64'(vt[i].p ? n_r1 - q : n_r0 - p), 64'd1);
      chk($sformatf("vec%0d_other_pulse", i), 64'(vt[i].p ? n_r0 - p : n_r1 - q), 64'd0);
    end
    // both ports held continuously: starvation counter forces port 1 every fifth grant
    do_reset();
    gq.delete();
    fork
      for (int k = 0; k < 8; k++) issue(0, 0, 64'(k * 8), 64'h0);
      for (int k = 0; k < 2; k++) issue(1, 0, 64'(64 + k * 8), 64'h0);
    join
    cycles(2);
    chk("t3_grant_count", 64'(gq.size()), 64'd10);
    for (int i = 0; i < 10 && i < gq.size(); i++) chk($sformatf("t3_grant%0d", i), 64'(gq[i]), 64'(exp_g[i]));
    // simultaneous port-1 store and port-0 load to the same address
    do_reset();
    fork
      issue(1, 1, 8, 64'hFFFF_0000_AAAA_5555);
      issue(0, 0, 8, 64'h0);
    join
    cycles(2);
    chk("t4_p0_old_data", last_r0, 64'h0);
    issue(1, 0, 8, 64'h0);
    cycles(2);
    chk("t4_p1_new_data", last_r1, 64'hFFFF_0000_AAAA_5555);
    // reset during the memory cycle of a store abandons it
    issue(0, 1, 16, 64'h5555_5555_5555_5555);
    cycles(2);
    p = n_r0; q = n_mw;
    issue(0, 1, 16, 64'h9876_5432_10FE_DCBA);
    reset_n = 0;
    cycles(1);
    reset_n = 1;
    cycles(2);
    chk("t5_no_resp", 64'(n_r0), 64'(p));
    chk("t5_no_memwrite", 64'(n_mw), 64'(q));
    issue(0, 0, 16, 64'h0);
    cycles(2);
    chk("t5_prior_value", last_r0, 64'h5555_5555_5555_5555);
    // misaligned load
    p = n_mr;
    issue(0, 0, 3, 64'h0);
    cycles(2);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("t6_err", last_e0, 1'b1);
    chk("t6_rdata", last_r0, 64'h0);
    chk("t6_no_memread", 64'(n_mr), 64'(p));
`else
    chk("t6_err", last_e0, 1'b0);
    chk("t6_rdata", last_r0, 64'h1122_3344_5566_7788);
    chk("t6_memread", 64'(n_mr), 64'(p + 1));
`endif
    // random two-port traffic checked by the model
    do_reset();
    fork
      rnd_port(0);
      rnd_port(1);
    join
    cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
